// File: rtl/memory_responder_pkg.sv
// Shared bus constants for the memory responder: bus width and the NOP word
// returned on faulted reads.
package memory_responder_pkg;
  localparam int BUS_W = 32;
  // addi x0, x0, 0
  localparam logic [BUS_W-1:0] NOP_WORD = 32'h0000_0013;
endpackage

// File: rtl/memory_responder_sync_ram.sv
// Single-port synchronous word RAM with write enable and a registered read port.
// The array itself is never reset; only the read register is.
module memory_responder_sync_ram
  import memory_responder_pkg::*;
#(
  parameter int    DEPTH     = 256,
  parameter int    AW        = 8,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [BUS_W-1:0] wdata,
  output logic [BUS_W-1:0] rdata
);
  logic [BUS_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (en && we) mem[addr] <= wdata;

  // Read register only moves on a read, so it holds the last read word.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)          rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
endmodule

// File: rtl/memory_responder.sv
// Memory-side bus responder: accepts a read/write, waits WAIT_STATES cycles,
// performs the access on RESP entry and pulses oMemRdy for one cycle.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int               DEPTH       = 256,
  parameter int               WAIT_STATES = 2,
  parameter string            INIT_FILE   = "",
  parameter logic [BUS_W-1:0] FAULT_WORD  = NOP_WORD
) (
  input  logic             iClk,
  input  logic             nRst,
  input  logic [BUS_W-1:0] iMemAddr,
  input  logic [BUS_W-1:0] iMemData,
  input  logic             iMemRead,
  input  logic             iMemWrite,
  output logic [BUS_W-1:0] oMemData,
  output logic             oMemRdy,
  output logic             oMemFault,
  output logic             oBusy
);
  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [BUS_W-1:0] addr_q, data_q;
  logic             rd_q, wr_q;
  logic             rd_fault;
  logic [BUS_W-1:0] ram_rdata;

  logic [BUS_W-1:0] cur_addr, cur_data;
  logic             cur_rd, cur_wr;
  logic             start, access, in_range, bad;

  // With zero wait states the access happens on the acceptance edge, so the
  // live bus is used while IDLE and the latched copy afterwards.
  always_comb begin
    cur_addr = addr_q;
    cur_data = data_q;
    cur_rd   = rd_q;
    cur_wr   = wr_q;
    if (state == IDLE) begin
      cur_addr = iMemAddr;
      cur_data = iMemData;
      cur_rd   = iMemRead;
      cur_wr   = iMemWrite;
    end
  end

  assign start    = (state == IDLE) && (iMemRead || iMemWrite);
  assign access   = (start && WAIT_STATES == 0) || (state == WAIT && cnt == 4'd0);
  assign in_range = cur_addr < BUS_W'(DEPTH);
  assign bad      = (cur_rd && cur_wr) || !in_range;

  memory_responder_sync_ram #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (iClk),
    .rst_n (nRst),
    .en    (access && !bad),
    .we    (cur_wr),
    .addr  (cur_addr[AW-1:0]),
    .wdata (cur_data),
    .rdata (ram_rdata)
  );

  // Both mux inputs are registers; rd_fault picks the fault word after a bad read.
  assign oMemData = rd_fault ? FAULT_WORD : ram_rdata;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_fault  <= 1'b0;
      oMemRdy   <= 1'b0;
      oMemFault <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      oMemRdy   <= 1'b0;
      oMemFault <= 1'b0;
      if (access) begin
        oMemRdy   <= 1'b1;
        oMemFault <= bad;
        if (cur_rd) rd_fault <= bad;
      end
      case (state)
        IDLE: if (start) begin
          addr_q <= iMemAddr;
          data_q <= iMemData;
          rd_q   <= iMemRead;
          wr_q   <= iMemWrite;
          oBusy  <= 1'b1;
          if (WAIT_STATES == 0) state <= RESP;
          else begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: if (cnt == 4'd0) state <= RESP;
              else             cnt   <= cnt - 4'd1;
        RESP: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: expected data/fault/cycle pushed at
// acceptance, popped and compared on each ready pulse.
module tb_memory_responder;
  localparam int          W     = 2;
  localparam logic [31:0] FAULT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] data;
  logic        rdy, fault, busy;

  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] data0;
  logic        rdy0, fault0, busy0;

  always #5 clk = ~clk;

  memory_responder #(.DEPTH(256), .WAIT_STATES(W), .INIT_FILE(""), .FAULT_WORD(FAULT)) dut (
    .iClk(clk), .nRst(rst_n), .iMemAddr(addr), .iMemData(wdata),
    .iMemRead(rd), .iMemWrite(wr), .oMemData(data), .oMemRdy(rdy),
    .oMemFault(fault), .oBusy(busy));

  memory_responder #(.DEPTH(256), .WAIT_STATES(0), .INIT_FILE(""), .FAULT_WORD(FAULT)) dut0 (
    .iClk(clk), .nRst(rst_n), .iMemAddr(addr0), .iMemData(wdata0),
    .iMemRead(rd0), .iMemWrite(wr0), .oMemData(data0), .oMemRdy(rdy0),
    .oMemFault(fault0), .oBusy(busy0));

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [256];
  logic [31:0] last_data = '0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rdy) begin
      if (sb.size() == 0) chk("spurious_rdy", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdy_cycle", 32'(cyc), 32'(e.due));
        chk("rdy_data", data, e.data);
        chk("rdy_fault", {31'd0, fault}, {31'd0, e.fault});
      end
    end
  end

  // Drive one request; optionally keep it up one more cycle with a new address.
  task automatic req(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input bit hold, input logic [31:0] alt_a);
    exp_t e;
    logic bad;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    bad = (r && w) || (a >= 32'd256);
    if (r && !bad)  e.data = ref_mem[a[7:0]];
    else if (r)     e.data = FAULT;
    else            e.data = last_data;
    if (w && !bad) ref_mem[a[7:0]] = d;
    last_data = e.data;
    e.fault = bad;
    e.due   = cyc + W;
    sb.push_back(e);
    if (hold) begin
      addr = alt_a; wdata = ~d;
      @(posedge clk); #1;
      chk("busy_in_wait", {31'd0, busy}, 32'd1);
      rd = 1'b0; wr = 1'b0;
      repeat (W) @(posedge clk);
    end else begin
      rd = 1'b0; wr = 1'b0;
      repeat (W + 1) @(posedge clk);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy",   {31'd0, rdy},   32'd0);
    chk("reset_fault", {31'd0, fault}, 32'd0);
    chk("reset_busy",  {31'd0, busy},  32'd0);
    chk("reset_data",  data,           32'd0);
    @(negedge clk) rst_n = 1'b1;

    req(0, 1, 32'd20, 32'h22, 0, 0);
    req(1, 0, 32'd20, 0, 0, 0);
    req(0, 1, 32'd23, 32'h20, 0, 0);
    req(1, 0, 32'd23, 0, 0, 0);

    req(0, 1, 32'd44, 32'h44, 0, 0);
    req(1, 0, 32'd300, 0, 0, 0);
    req(0, 1, 32'd300, 32'hBAD, 0, 0);
    req(1, 0, 32'd44, 0, 0, 0);
    req(1, 0, 32'h1000_002C, 0, 0, 0);

    req(0, 1, 32'd5, 32'h5, 0, 0);
    req(1, 1, 32'd5, 32'hFF, 0, 0);
    req(1, 0, 32'd5, 0, 0, 0);

    req(0, 1, 32'd21, 32'h21, 0, 0);
    req(1, 0, 32'd20, 0, 1, 32'd21);
    req(0, 1, 32'd30, 32'h77, 1, 32'd31);
    req(1, 0, 32'd30, 0, 0, 0);
    req(1, 0, 32'd31, 0, 0, 0);

    // Reset in the middle of a write's wait: no pulse, no commit.
    req(0, 1, 32'd10, 32'hA0A0, 0, 0);
    @(negedge clk);
    wr = 1'b1; addr = 32'd10; wdata = 32'h1234;
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_rdy",   {31'd0, rdy},   32'd0);
    chk("midrst_fault", {31'd0, fault}, 32'd0);
    chk("midrst_busy",  {31'd0, busy},  32'd0);
    chk("midrst_data",  data,           32'd0);
    last_data = '0;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    req(1, 0, 32'd10, 0, 0, 0);

    // Zero wait states: ready during the cycle right after acceptance.
    @(negedge clk);
    wr0 = 1'b1; addr0 = 32'd3; wdata0 = 32'h55;
    @(posedge clk); #1;
    wr0 = 1'b0;
    @(negedge clk);
    chk("w0_wr_rdy",   {31'd0, rdy0},   32'd1);
    chk("w0_wr_fault", {31'd0, fault0}, 32'd0);
    chk("w0_wr_busy",  {31'd0, busy0},  32'd1);
    @(posedge clk); #1;
    chk("w0_idle_rdy", {31'd0, rdy0}, 32'd0);
    @(negedge clk);
    rd0 = 1'b1; addr0 = 32'd3;
    @(posedge clk); #1;
    rd0 = 1'b0;
    @(negedge clk);
    chk("w0_rd_rdy",  {31'd0, rdy0}, 32'd1);
    chk("w0_rd_data", data0,         32'h55);

    repeat (W + 4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
